// File: rtl/instr_queue.sv
// Fetch-to-decode instruction buffer.
//
// Records the pc/order of every imem request fetch issues, pairs each in-order imem response
// with its request, and buffers the result for decode over a valid/ready handshake. On a
// branch flush everything queued is discarded and every response still in flight is counted
// as stale so that it is dropped when it arrives.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   flush          branch taken: kill queued and in-flight instructions
//   req_valid      fetch issued an imem request this cycle (req_pc, req_order)
//   imem_resp      imem returns imem_rdata this cycle, in request order
//   fetch_stall    fetch must not issue a request this cycle
//   iq_valid       head entry valid (iq_inst, iq_pc, iq_order)
//   dec_ready      decode consumes the head when iq_valid && dec_ready
//   iq_count       occupied instruction entries
module instr_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  input  logic [31:0]              req_pc,
  input  logic [63:0]              req_order,
  input  logic                     imem_resp,
  input  logic [31:0]              imem_rdata,
  output logic                     fetch_stall,
  output logic                     iq_valid,
  output logic [31:0]              iq_inst,
  output logic [31:0]              iq_pc,
  output logic [63:0]              iq_order,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned PendPtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned PendCntW = $clog2(MAX_OUTSTANDING) + 1;

  // Instruction storage
  logic [31:0] q_inst  [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [63:0] q_order [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pending (issued, not yet answered) request storage
  logic [31:0] p_pc    [MAX_OUTSTANDING];
  logic [63:0] p_order [MAX_OUTSTANDING];
  logic [PendPtrW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [PendCntW-1:0] pend_cnt_q, pend_cnt_d;

  // Responses still owed by imem for requests killed by a flush
  logic [PendCntW-1:0] stale_cnt_q, stale_cnt_d;

  logic        req_fire, resp_live, q_push, q_pop, pend_push, pend_pop;
  logic [31:0] occ_sum, out_sum, flush_stale;

  function automatic logic [PendPtrW-1:0] pend_inc(input logic [PendPtrW-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + PendPtrW'(1);
  endfunction

  // Stall only looks at registered state; each live request already owns a queue slot.
  assign occ_sum     = 32'(count_q) + 32'(pend_cnt_q);
  assign out_sum     = 32'(pend_cnt_q) + 32'(stale_cnt_q);
  assign fetch_stall = (occ_sum >= DEPTH) || (out_sum == MAX_OUTSTANDING);

  assign req_fire  = req_valid && !fetch_stall;
  assign resp_live = imem_resp && (stale_cnt_q == '0);
  assign iq_valid  = (count_q != '0) && !flush;
  assign q_pop     = iq_valid && dec_ready;
  assign q_push    = resp_live && !flush;
  assign pend_push = req_fire && !flush;
  assign pend_pop  = resp_live && !flush;

  // A response in the flush cycle consumes either a stale slot or the pending head;
  // either way it leaves the in-flight total.
  assign flush_stale = 32'(stale_cnt_q) + 32'(pend_cnt_q) + 32'(req_fire) - 32'(imem_resp);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    pend_cnt_d  = pend_cnt_q;
    stale_cnt_d = stale_cnt_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      pend_rd_d   = '0;
      pend_wr_d   = '0;
      pend_cnt_d  = '0;
      stale_cnt_d = PendCntW'(flush_stale);
    end else begin
      if (q_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (q_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(q_push) - CntW'(q_pop);
      if (pend_push) pend_wr_d = pend_inc(pend_wr_q);
      if (pend_pop)  pend_rd_d = pend_inc(pend_rd_q);
      pend_cnt_d = pend_cnt_q + PendCntW'(pend_push) - PendCntW'(pend_pop);
      if (imem_resp && (stale_cnt_q != '0)) stale_cnt_d = stale_cnt_q - PendCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pend_rd_q   <= '0;
      pend_wr_q   <= '0;
      pend_cnt_q  <= '0;
      stale_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      pend_cnt_q  <= pend_cnt_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  // Storage arrays need no reset: contents are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (!rst && q_push) begin
      q_inst[wr_ptr_q]  <= imem_rdata;
      q_pc[wr_ptr_q]    <= p_pc[pend_rd_q];
      q_order[wr_ptr_q] <= p_order[pend_rd_q];
    end
    if (!rst && pend_push) begin
      p_pc[pend_wr_q]    <= req_pc;
      p_order[pend_wr_q] <= req_order;
    end
  end

  assign iq_count = count_q;
  assign iq_inst  = (count_q != '0) ? q_inst[rd_ptr_q]  : '0;
  assign iq_pc    = (count_q != '0) ? q_pc[rd_ptr_q]    : '0;
  assign iq_order = (count_q != '0) ? q_order[rd_ptr_q] : '0;

  // Counter range checks
  a_resp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(resp_live && (pend_cnt_q == '0)));
  a_queue_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && !q_pop && (count_q == CntW'(DEPTH))));
  a_pend_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pend_push && !pend_pop && (32'(pend_cnt_q) == MAX_OUTSTANDING)));
  a_stale_range: assert property (@(posedge clk) disable iff (rst)
    !(flush && ((32'(stale_cnt_q) + 32'(pend_cnt_q) + 32'(req_fire) < 32'(imem_resp))
                || (flush_stale > MAX_OUTSTANDING))));

endmodule
